display_arbiter: RTL
====================

# display_arbiter

Shares the candy vending machine's 8-digit seven-segment display between three sources: live balance/candy count (default), a timed "dispense" message and a blinking "refund" message. It also generates the column-scan tick that paces the digit multiplexer. It sits between the vending FSM and the seven-segment column selector, which consumes its `sum`, `candy_sum`, `blank` and `scan_tick` outputs.

## Interface
- `TICK_DIV`, 50000: clock cycles per scan tick; must be ≥ 2.
- `HOLD_TICKS`, 500: scan ticks a dispense or refund message stays on the display; must be ≥ 1.
- `BLINK_TICKS`, 125: scan ticks per blink half-period in refund mode; must be ≥ 1.

Ports:
- `clk` in 1: single system clock. Reset is synchronous and active-high.
- `reset` in 1: synchronous, active-high.
- `sum_in` in 8: live inserted-coin balance.
- `candy_sum_in` in 3: live selected-candy count.
- `dispense_req` in 1: one-cycle pulse requesting the dispense message.
- `dispense_candy` in 3: candy count to show; sampled with `dispense_req`.
- `refund_req` in 1: one-cycle pulse requesting the refund message.
- `refund_amt` in 8: amount to show; sampled with `refund_req`.
- `sum` out 8: value to the display's sum field.
- `candy_sum` out 3: value to the display's candy field.
- `blank` out 1: 1 means all digits are off.
- `scan_tick` out 1: one-cycle pulse every `TICK_DIV` clocks.
- `msg_code` out 2: current mode. 0 = BAL, 1 = DISP, 2 = REFUND.
- `dispense_ack` out 1: one-cycle pulse when the dispense request is granted.
- `refund_ack` out 1: one-cycle pulse when the refund request is granted.

## Operation
- **Reset values.** All outputs are 0, state is BAL, and all counters and pending flags are cleared. A reset asserted mid-message drops the message and any pending requests.
- **Request capture.** A request pulse sets a pending flag and captures its data into a slot.
  - A repeat request before the grant overwrites the slot.
  - A request that arrives while its own message is being shown is queued and served after the current hold expires.
- **FSM states:** BAL, DISP, REFUND.
- **BAL:**
  - `sum`/`candy_sum` follow `sum_in`/`candy_sum_in` through one register stage; `blank` = 0.
  - If a refund is pending, go to REFUND. Otherwise, if a dispense is pending, go to DISP.
  - Refund has priority.
- **Grant.** On the transition into a message state:
  - The slot is loaded into the outputs and the pending flag is cleared.
  - The matching ack pulses for one cycle.
  - The hold counter and blink counter are zeroed.
- **DISP:** `sum` = 0, `candy_sum` = captured candy, `blank` = 0.
- **REFUND:** `sum` = captured amount, `candy_sum` = 0. `blank` starts at 0 and toggles on every `BLINK_TICKS`-th scan tick.
- **Hold expiry.** The hold counter increments on each `scan_tick`. On the `HOLD_TICKS`-th tick the state leaves the message state:
  - It goes to REFUND if a refund is pending, else DISP if a dispense is pending, else BAL.
  - Message-to-message moves are granted exactly like grants from BAL.
- **No preemption.** A refund request arriving during DISP waits for DISP to expire.
- **Simultaneous requests.** Refund is granted first. Dispense is granted at refund expiry.
- **Prescaler.** Counts 0..`TICK_DIV`-1 and wraps. `scan_tick` pulses on the wrap cycle. It runs in all states and is unaffected by state changes.
- **Widths.**
  - Prescaler: $clog2(`TICK_DIV`) bits.
  - Hold counter: $clog2(`HOLD_TICKS`+1) bits.
  - Blink counter: $clog2(`BLINK_TICKS`+1) bits.
  - Counters never overflow: hold clears on exit, blink clears on each toggle.

## Timing
- Request pulse sampled at edge k → pending visible after edge k.
- If the FSM is in BAL, the grant occurs at edge k+1: new `msg_code`/`sum`/`candy_sum` and the ack are valid after edge k+1. Grant latency is therefore 2 cycles from the request cycle.
- `sum_in` change at edge k → `sum` updated after edge k+1 (BAL only).
- First `scan_tick` is high during the cycle after edge `TICK_DIV` counted from reset release, then every `TICK_DIV` cycles.
- Hold expiry transition occurs on the clock edge at which the `HOLD_TICKS`-th `scan_tick` is sampled.
- `blank` toggles on the edge sampling the qualifying tick. `blank` is forced to 0 on leaving REFUND.
- All outputs are registered; no combinational input-to-output paths.

## Structure
- Shared package `display_arb_pkg` holds:
  - the state encoding (BAL=0, DISP=1, REFUND=2), reused as `msg_code`;
  - the default parameter constants.
- Sub-module `tick_prescaler`: parameter `TICK_DIV`; ports `clk`, `reset`, `tick`.
- The FSM, request slots, and hold/blink counters live in `display_arbiter`.

## Test plan
All scenarios use `TICK_DIV`=4, `HOLD_TICKS`=3, `BLINK_TICKS`=1.
- **Reset:** all outputs 0; first `scan_tick` after 4 clocks; ticks periodic every 4 thereafter.
- **BAL tracking:** `sum_in`=0x37, `candy_sum_in`=5 → `sum`=0x37, `candy_sum`=5 one cycle later; `msg_code`=0.
- **Dispense:** `dispense_req` with candy=3 → after 2 cycles `dispense_ack`=1 for 1 cycle, `msg_code`=1, `candy_sum`=3, `sum`=0; BAL resumes on the 3rd tick.
- **Refund:** `refund_req` with amt=0x50 → `msg_code`=2, `sum`=0x50; `blank` toggles 0,1,0 on successive ticks; returns to BAL with `blank`=0.
- **Simultaneous:** `dispense_req` and `refund_req` in the same cycle → `refund_ack` first, REFUND for 3 ticks, then `dispense_ack` and DISP, then BAL.
- **Reset mid-message:** `reset` during REFUND with a dispense pending → next cycle `msg_code`=0, all outputs 0, no later `dispense_ack`.

Source files
------------

// File: rtl/display_arb_pkg.sv
// Shared definitions for the vending-machine display arbiter: mode encoding,
// field widths and default timing constants.
package display_arb_pkg;

  typedef enum logic [1:0] {
    ST_BAL    = 2'd0,
    ST_DISP   = 2'd1,
    ST_REFUND = 2'd2
  } state_e;

  localparam int unsigned MSG_W   = 2;
  localparam int unsigned SUM_W   = 8;
  localparam int unsigned CANDY_W = 3;

  localparam int unsigned DEF_TICK_DIV    = 50000;
  localparam int unsigned DEF_HOLD_TICKS  = 500;
  localparam int unsigned DEF_BLINK_TICKS = 125;

endpackage

// File: rtl/display_arbiter_tick_prescaler.sv
// Free-running divider producing a registered one-cycle tick every TICK_DIV
// clocks; it paces the digit scan and all message timing.
module tick_prescaler
  import display_arb_pkg::*;
#(
  parameter int unsigned TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q + CNT_W'(1);
    tick_d = 1'b0;
    if (cnt_q == CNT_LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/display_arbiter.sv
// Arbitrates the 8-digit display between live balance, a timed dispense
// message and a blinking refund message; all outputs are registered.
module display_arbiter
  import display_arb_pkg::*;
#(
  parameter int unsigned TICK_DIV    = DEF_TICK_DIV,
  parameter int unsigned HOLD_TICKS  = DEF_HOLD_TICKS,
  parameter int unsigned BLINK_TICKS = DEF_BLINK_TICKS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SUM_W-1:0]   sum_in,
  input  logic [CANDY_W-1:0] candy_sum_in,
  input  logic               dispense_req,
  input  logic [CANDY_W-1:0] dispense_candy,
  input  logic               refund_req,
  input  logic [SUM_W-1:0]   refund_amt,
  output logic [SUM_W-1:0]   sum,
  output logic [CANDY_W-1:0] candy_sum,
  output logic               blank,
  output logic               scan_tick,
  output logic [MSG_W-1:0]   msg_code,
  output logic               dispense_ack,
  output logic               refund_ack
);

  localparam int unsigned HOLD_W  = $clog2(HOLD_TICKS + 1);
  localparam int unsigned BLINK_W = $clog2(BLINK_TICKS + 1);
  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(HOLD_TICKS - 1);
  localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_TICKS - 1);

  state_e               state_q, state_d;
  logic                 tick;
  logic                 expire_c, grant_c;
  logic                 disp_pend_q, disp_pend_d;
  logic                 ref_pend_q, ref_pend_d;
  logic [CANDY_W-1:0]   disp_slot_q, disp_slot_d;
  logic [SUM_W-1:0]     ref_slot_q, ref_slot_d;
  logic [HOLD_W-1:0]    hold_q, hold_d;
  logic [BLINK_W-1:0]   blink_q, blink_d;
  logic [SUM_W-1:0]     sum_q, sum_d;
  logic [CANDY_W-1:0]   candy_q, candy_d;
  logic                 blank_q, blank_d;
  logic                 dack_q, dack_d;
  logic                 rack_q, rack_d;

  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .tick (tick)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_BAL;
    end else begin
      state_q <= state_d;
    end
  end

  // Next mode: refund beats dispense, and a message is never cut short.
  always_comb begin
    state_d  = state_q;
    expire_c = 1'b0;
    grant_c  = 1'b0;
    case (state_q)
      ST_BAL: begin
        grant_c = ref_pend_q | disp_pend_q;
        if (ref_pend_q) begin
          state_d = ST_REFUND;
        end else if (disp_pend_q) begin
          state_d = ST_DISP;
        end
      end
      ST_DISP, ST_REFUND: begin
        expire_c = tick && (hold_q == HOLD_LAST);
        if (expire_c) begin
          grant_c = ref_pend_q | disp_pend_q;
          if (ref_pend_q) begin
            state_d = ST_REFUND;
          end else if (disp_pend_q) begin
            state_d = ST_DISP;
          end else begin
            state_d = ST_BAL;
          end
        end
      end
      default: begin
        state_d = ST_BAL;
      end
    endcase
  end

  // A fresh request wins over the clear from a same-cycle grant so it is not lost.
  always_comb begin
    disp_pend_d = disp_pend_q;
    ref_pend_d  = ref_pend_q;
    disp_slot_d = disp_slot_q;
    ref_slot_d  = ref_slot_q;
    if (grant_c && (state_d == ST_DISP)) begin
      disp_pend_d = 1'b0;
    end
    if (grant_c && (state_d == ST_REFUND)) begin
      ref_pend_d = 1'b0;
    end
    if (dispense_req) begin
      disp_pend_d = 1'b1;
      disp_slot_d = dispense_candy;
    end
    if (refund_req) begin
      ref_pend_d = 1'b1;
      ref_slot_d = refund_amt;
    end
  end

  // Display fields and timers, computed from the mode being entered.
  always_comb begin
    sum_d   = sum_q;
    candy_d = candy_q;
    blank_d = blank_q;
    hold_d  = hold_q;
    blink_d = blink_q;
    dack_d  = 1'b0;
    rack_d  = 1'b0;
    case (state_d)
      ST_DISP: begin
        blank_d = 1'b0;
        blink_d = '0;
        if (grant_c) begin
          sum_d   = '0;
          candy_d = disp_slot_q;
          hold_d  = '0;
          dack_d  = 1'b1;
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      ST_REFUND: begin
        if (grant_c) begin
          sum_d   = ref_slot_q;
          candy_d = '0;
          blank_d = 1'b0;
          hold_d  = '0;
          blink_d = '0;
          rack_d  = 1'b1;
        end else if (tick) begin
          hold_d = hold_q + HOLD_W'(1);
          if (blink_q == BLINK_LAST) begin
            blank_d = ~blank_q;
            blink_d = '0;
          end else begin
            blink_d = blink_q + BLINK_W'(1);
          end
        end
      end
      default: begin
        sum_d   = sum_in;
        candy_d = candy_sum_in;
        blank_d = 1'b0;
        hold_d  = '0;
        blink_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      disp_pend_q <= 1'b0;
      ref_pend_q  <= 1'b0;
      disp_slot_q <= '0;
      ref_slot_q  <= '0;
      hold_q      <= '0;
      blink_q     <= '0;
      sum_q       <= '0;
      candy_q     <= '0;
      blank_q     <= 1'b0;
      dack_q      <= 1'b0;
      rack_q      <= 1'b0;
    end else begin
      disp_pend_q <= disp_pend_d;
      ref_pend_q  <= ref_pend_d;
      disp_slot_q <= disp_slot_d;
      ref_slot_q  <= ref_slot_d;
      hold_q      <= hold_d;
      blink_q     <= blink_d;
      sum_q       <= sum_d;
      candy_q     <= candy_d;
      blank_q     <= blank_d;
      dack_q      <= dack_d;
      rack_q      <= rack_d;
    end
  end

  assign sum          = sum_q;
  assign candy_sum    = candy_q;
  assign blank        = blank_q;
  assign scan_tick    = tick;
  assign msg_code     = state_q;
  assign dispense_ack = dack_q;
  assign refund_ack   = rack_q;

endmodule
